controller: RTL and testbench

- Instruction decoder for the 5-stage MIPS pipeline.
- Classifies a 32-bit instruction combinationally (branch, jump, load, store, etc.) and produces the GRF write address. The IF stage uses ifBranch|ifJump to mark delay-slot instructions.
- Also holds a registered copy of the decode bundle for the next pipeline stage, with stall and flush control.

---
 rtl/controller.sv | 130 +++++++++++++
 tb/tb_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// MIPS instruction decoder: combinational class/GRF-write-address decode plus a
// registered copy with stall/flush. Define CP0_EN to decode mfc0/mtc0/eret.
module controller #(
   parameter logic [4:0]  RA_REG  = 5'd31,
   parameter logic [11:0] NOP_CLS = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        stall,
   input  logic        flush,
   output logic        ifBranch,
   output logic        ifJump,
   output logic [11:0] cls,
   output logic [4:0]  grfWa,
   output logic [11:0] cls_q,
   output logic [4:0]  grfWa_q
);

   localparam int BRANCH = 0;
   localparam int JUMP   = 1;
   localparam int LOAD   = 2;
   localparam int STORE  = 3;
   localparam int CALR   = 4;
   localparam int CALI   = 5;
   localparam int MD     = 6;
   localparam int MF     = 7;
   localparam int MT     = 8;
   localparam int MFC0   = 9;
   localparam int MTC0   = 10;
   localparam int RI     = 11;

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;

   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign rs = instr[25:21];
   assign rt = instr[20:16];
   assign rd = instr[15:11];

   // Anything not explicitly matched lands in the reserved-instruction class
   always_comb begin
      cls   = '0;
      grfWa = '0;
      case (op)
         6'h00: begin
            case (fn)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  cls[CALR] = 1'b1;
                  grfWa     = rd;
               end
               6'h08: cls[JUMP] = 1'b1;
               6'h09: begin
                  cls[JUMP] = 1'b1;
                  grfWa     = rd;
               end
               6'h10, 6'h12: begin
                  cls[MF] = 1'b1;
                  grfWa   = rd;
               end
               6'h11, 6'h13: cls[MT] = 1'b1;
               6'h18, 6'h19, 6'h1A, 6'h1B: cls[MD] = 1'b1;
               default: cls[RI] = 1'b1;
            endcase
         end
         6'h01: begin
            if (rt == 5'd0 || rt == 5'd1)
               cls[BRANCH] = 1'b1;
            else
               cls[RI] = 1'b1;
         end
         6'h02: cls[JUMP] = 1'b1;
         6'h03: begin
            cls[JUMP] = 1'b1;
            grfWa     = RA_REG;
         end
         6'h04, 6'h05, 6'h06, 6'h07: cls[BRANCH] = 1'b1;
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            cls[CALI] = 1'b1;
            grfWa     = rt;
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            cls[LOAD] = 1'b1;
            grfWa     = rt;
         end
         6'h28, 6'h29, 6'h2B: cls[STORE] = 1'b1;
`ifdef CP0_EN
         6'h10: begin
            if (instr == 32'h42000018)
               cls[MTC0] = 1'b1;
            else if (rs == 5'd0) begin
               cls[MFC0] = 1'b1;
               grfWa     = rt;
            end
            else if (rs == 5'd4)
               cls[MTC0] = 1'b1;
            else
               cls[RI] = 1'b1;
         end
`endif
         default: cls[RI] = 1'b1;
      endcase
   end

   assign ifBranch = cls[BRANCH];
   assign ifJump   = cls[JUMP];

   // Flush inserts a bubble even when the stage is also stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cls_q   <= NOP_CLS;
         grfWa_q <= '0;
      end
      else if (flush) begin
         cls_q   <= NOP_CLS;
         grfWa_q <= '0;
      end
      else if (!stall) begin
         cls_q   <= cls;
         grfWa_q <= grfWa;
      end
   end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: a mask/value instruction table is the reference
// decoder; a monitor process checks combinational and registered outputs.
module tb_controller;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        stall;
   logic        flush;
   logic        ifBranch;
   logic        ifJump;
   logic [11:0] cls;
   logic [4:0]  grfWa;
   logic [11:0] cls_q;
   logic [4:0]  grfWa_q;

   controller dut (
      .clk(clk), .reset(reset), .instr(instr), .stall(stall), .flush(flush),
      .ifBranch(ifBranch), .ifJump(ifJump), .cls(cls), .grfWa(grfWa),
      .cls_q(cls_q), .grfWa_q(grfWa_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // wa source: 0 none, 1 rd, 2 rt, 3 return-address register
   typedef struct {
      logic [31:0] mask;
      logic [31:0] value;
      int          bitn;
      int          wa;
   } rule_t;

   typedef struct {
      logic [31:0] instr;
      logic [11:0] cls;
      logic [4:0]  wa;
   } exp_t;

   rule_t rules[$];
   exp_t  comb_q[$];
   exp_t  reg_q[$];

   int checks   = 0;
   int failures = 0;

   logic [11:0] model_cls_q;
   logic [4:0]  model_wa_q;

   function automatic void addRule(input logic [31:0] mask, input logic [31:0] value,
                                   input int bitn, input int wa);
      rule_t r;
      r.mask  = mask;
      r.value = value;
      r.bitn  = bitn;
      r.wa    = wa;
      rules.push_back(r);
   endfunction

   function automatic void buildRules();
      int aluFn[16] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
                        'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
      int loadOp[5]  = '{'h20, 'h21, 'h23, 'h24, 'h25};
      int storeOp[3] = '{'h28, 'h29, 'h2B};
      foreach (aluFn[k]) addRule(32'hFC00003F, 32'(aluFn[k]), 4, 1);
      addRule(32'hFC00003F, 32'h08, 1, 0);
      addRule(32'hFC00003F, 32'h09, 1, 1);
      addRule(32'hFC00003F, 32'h10, 7, 1);
      addRule(32'hFC00003F, 32'h12, 7, 1);
      addRule(32'hFC00003F, 32'h11, 8, 0);
      addRule(32'hFC00003F, 32'h13, 8, 0);
      for (int f = 'h18; f <= 'h1B; f++) addRule(32'hFC00003F, 32'(f), 6, 0);
      addRule(32'hFC1F0000, 32'h04000000, 0, 0);
      addRule(32'hFC1F0000, 32'h04010000, 0, 0);
      addRule(32'hFC000000, 32'h08000000, 1, 0);
      addRule(32'hFC000000, 32'h0C000000, 1, 3);
      for (int o = 4; o <= 7; o++) addRule(32'hFC000000, 32'(o) << 26, 0, 0);
      for (int o = 8; o <= 15; o++) addRule(32'hFC000000, 32'(o) << 26, 5, 2);
      foreach (loadOp[k]) addRule(32'hFC000000, 32'(loadOp[k]) << 26, 2, 2);
      foreach (storeOp[k]) addRule(32'hFC000000, 32'(storeOp[k]) << 26, 3, 0);
`ifdef CP0_EN
      addRule(32'hFFE00000, 32'h40000000, 9, 2);
      addRule(32'hFFE00000, 32'h40800000, 10, 0);
      addRule(32'hFFFFFFFF, 32'h42000018, 10, 0);
`endif
   endfunction

   function automatic void decodeModel(input logic [31:0] i, output logic [11:0] c,
                                       output logic [4:0] w);
      c = 12'h800;
      w = 5'd0;
      foreach (rules[k]) begin
         if ((i & rules[k].mask) == rules[k].value) begin
            c = 12'h001 << rules[k].bitn;
            case (rules[k].wa)
               1:       w = i[15:11];
               2:       w = i[20:16];
               3:       w = 5'd31;
               default: w = 5'd0;
            endcase
         end
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] which,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s instr=%h actual=%h expected=%h", name, which, act, exp);
      end
   endtask

   // One instruction per cycle; the register expectation applies after the next edge
   task automatic applyStimulus(input logic [31:0] i, input logic s, input logic f);
      exp_t e;
      exp_t r;
      @(posedge clk);
      #1;
      instr = i;
      stall = s;
      flush = f;
      e.instr = i;
      decodeModel(i, e.cls, e.wa);
      comb_q.push_back(e);
      if (f) begin
         model_cls_q = 12'h000;
         model_wa_q  = 5'd0;
      end
      else if (!s) begin
         model_cls_q = e.cls;
         model_wa_q  = e.wa;
      end
      r.instr = i;
      r.cls   = model_cls_q;
      r.wa    = model_wa_q;
      reg_q.push_back(r);
   endtask

   function automatic logic [31:0] randomInstr();
      logic [31:0] r;
      logic [4:0]  rsel;
      int          k;
      r = $urandom;
      case ($urandom % 4)
         0, 1: begin
            k = $urandom % rules.size();
            return (r & ~rules[k].mask) | rules[k].value;
         end
         2: begin
            case ($urandom % 4)
               0:       rsel = 5'd0;
               1:       rsel = 5'd4;
               2:       rsel = 5'd16;
               default: rsel = r[25:21];
            endcase
            if ($urandom % 2 == 0)
               return {6'h10, rsel, r[20:0]};
            return {6'h01, r[25:0]};
         end
         default: return r;
      endcase
   endfunction

   // Monitor: combinational results checked each cycle, register results one cycle later
   initial begin
      exp_t e;
      exp_t pend;
      logic havePend;
      havePend = 1'b0;
      forever begin
         @(negedge clk);
         if (havePend) begin
            checkOutput("cls_q", pend.instr, 32'(cls_q), 32'(pend.cls));
            checkOutput("grfWa_q", pend.instr, 32'(grfWa_q), 32'(pend.wa));
         end
         while (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            checkOutput("cls", e.instr, 32'(cls), 32'(e.cls));
            checkOutput("grfWa", e.instr, 32'(grfWa), 32'(e.wa));
            checkOutput("ifBranch", e.instr, 32'(ifBranch), 32'(e.cls[0]));
            checkOutput("ifJump", e.instr, 32'(ifJump), 32'(e.cls[1]));
         end
         if (reg_q.size() > 0) begin
            pend     = reg_q.pop_front();
            havePend = 1'b1;
         end
         else begin
            havePend = 1'b0;
         end
      end
   end

   initial begin
      buildRules();
      reset = 1'b1;
      instr = 32'h00221821;
      stall = 1'b1;
      flush = 1'b0;
      model_cls_q = 12'h000;
      model_wa_q  = 5'd0;
      #2;
      checkOutput("reset_cls_q", instr, 32'(cls_q), 32'h0);
      checkOutput("reset_grfWa_q", instr, 32'(grfWa_q), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(32'h10220003, 1'b0, 1'b0);
      applyStimulus(32'h0C000C00, 1'b0, 1'b0);
      applyStimulus(32'h00221821, 1'b0, 1'b0);
      applyStimulus(32'h8C250004, 1'b0, 1'b0);
      applyStimulus(32'h04010002, 1'b0, 1'b0);
      applyStimulus(32'h04050002, 1'b0, 1'b0);
      applyStimulus(32'h42000018, 1'b0, 1'b0);
      applyStimulus(32'h40033000, 1'b0, 1'b0);
      applyStimulus(32'h00000000, 1'b0, 1'b0);
      applyStimulus(32'h00221821, 1'b0, 1'b0);
      applyStimulus(32'h8C250004, 1'b1, 1'b0);
      applyStimulus(32'h0C000C00, 1'b1, 1'b1);
      applyStimulus(32'h00221821, 1'b0, 1'b0);

      // Park the stage with a loaded value, then reset between edges
      @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_cls_q", instr, 32'(cls_q), 32'h0);
      checkOutput("async_reset_grfWa_q", instr, 32'(grfWa_q), 32'h0);
      #1;
      reset = 1'b0;
      model_cls_q = 12'h000;
      model_wa_q  = 5'd0;

      for (int n = 0; n < 400; n++)
         applyStimulus(randomInstr(), ($urandom % 4) == 0, ($urandom % 10) == 0);

      @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
